column_token_parser: RTL and testbench
======================================

# column_token_parser

Upstream feeder for the column reducer. Consumes a byte-wide ASCII worksheet stream (decimal numbers, separators, a trailing operator per column) and emits the `num_valid`/`num_in`, `op_valid`/`op_in` and `done` strobes the reducer expects. The reducer loses data if a number, the operator and `done` share a cycle, so this block serialises them into separate cycles and back-pressures the byte source while doing so.

## Interface
- `NUM_W`, 32: width of parsed numbers; matches the reducer's `num_in`.
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  byte source has a byte on `in_data`.
- `in_data`  in  8  ASCII byte.
- `in_ready`  out  1  block accepts a byte this cycle; accept = `in_valid && in_ready`.
- `num_valid`  out  1  one-cycle strobe, `num_in` holds a completed number.
- `num_in`  out  NUM_W  parsed number.
- `op_valid`  out  1  one-cycle strobe, `op_in` holds the column operator.
- `op_in`  out  1  0 = add (`+`), 1 = mul (`*`).
- `done`  out  1  one-cycle strobe, column complete.
- `err`  out  1  sticky: overflow or illegal byte seen since reset.

## Operation
- States: ACCEPT, OP_ST, DONE_ST. `in_ready` = (state == ACCEPT), combinational from state only.
- Internal: `acc` (NUM_W), `pending` (1 = at least one digit since last emitted number).
- Accepted byte in ACCEPT, classified:
  - Digit `0`-`9` (0x30-0x39): `acc <= acc*10 + d`, `pending <= 1`. No output.
  - Separator (space 0x20, LF 0x0A, CR 0x0D): if `pending`, `num_valid <= 1`, `num_in <= acc`, clear `acc`/`pending`; else nothing. Stay in ACCEPT.
  - Operator `+` (0x2B) / `*` (0x2A): latch op. If `pending`, emit number as above, go OP_ST. Else `op_valid <= 1`, `op_in <= op`, go DONE_ST.
  - Any other byte: ignored, `err <= 1`; `acc`/`pending` untouched.
- OP_ST: `op_valid <= 1`, `op_in <= latched op`, go DONE_ST.
- DONE_ST: `done <= 1`, go ACCEPT.
- Operator with no numbers in the column still emits `op_valid` then `done` (reducer reports 0 for add, 1 for mul).
- Arithmetic: `acc*10 + d` computed at NUM_W+4 bits; if result > 2^NUM_W-1, `acc <= 2^NUM_W-1` (saturate, stays saturated for remaining digits) and `err <= 1`. Leading zeros legal.
- `num_valid`, `op_valid`, `done` never asserted in the same cycle.
- `in_valid` without `in_ready`: byte is not consumed; source must hold it.

## Timing
- All strobe outputs registered; each high exactly one cycle.
- Separator accepted in cycle N with `pending`: `num_valid` high N+1; `in_ready` stays high (no stall, back-to-back bytes allowed).
- Operator accepted in N with `pending`: `num_valid` N+1, `op_valid` N+2, `done` N+3; `in_ready` low N+1..N+2, high again N+3 (byte may be accepted in N+3).
- Operator accepted in N without `pending`: `op_valid` N+1, `done` N+2; `in_ready` low N+1, high N+2.
- `num_in`/`op_in` hold last value between strobes.
- Reset values: `in_ready` 1 (state ACCEPT), `num_valid` 0, `num_in` 0, `op_valid` 0, `op_in` 0, `done` 0, `err` 0, `acc` 0, `pending` 0.
- Reset mid-column (any state): all of the above restored next cycle; partial number and pending strobes discarded, no `done` emitted.

## Configuration
- `PARSER_COL_COUNT_EN` defined: adds output `col_count` (out, 16) counting `done` strobes; increments in the same cycle `done` is high (visible N+1 after); wraps 0xFFFF -> 0; reset 0.
- Not defined: port and counter absent; all other behaviour identical.

## Test plan
- Stream `"12 34+"` with `in_valid` held high -> `num_valid` with 12, then 34 (same cycle operator accepted + 1), `op_valid` `op_in`=0, then `done`; reducer result 46.
- Stream `"3\n4\n5\n*"` -> three `num_valid` (3,4,5), `op_valid` `op_in`=1 one cycle after `*` accept, `done` next cycle; `in_ready` low for exactly 1 cycle; reducer result 60.
- Stream `"7*"` (pending at operator) -> `num_valid`=7, `op_valid`, `done` in three consecutive cycles, `in_ready` low exactly 2 cycles, no two strobes coincident.
- Stream `"4294967296 "` -> `num_in`=0xFFFFFFFF, `err`=1 and stays 1; `"9x9 "` -> `err`=1, `num_in`=99.
- `"+"` alone -> `op_valid` then `done`, no `num_valid`; with `in_valid` toggling randomly, no byte dropped or duplicated.
- Assert `rst` in the cycle `op_valid` is high -> no `done` follows, all outputs at reset values; next `"5 +"` parses cleanly; with `PARSER_COL_COUNT_EN`, `col_count` reads 1 afterwards.

Source files
------------

// File: rtl/column_token_parser.sv
// Byte-stream worksheet parser feeding the column reducer: numbers, operator and done are serialised into separate cycles.
// Optional `PARSER_COL_COUNT_EN adds a 16-bit col_count output counting emitted done strobes.
module column_token_parser #(
  parameter int NUM_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             num_valid,
  output logic [NUM_W-1:0] num_in,
  output logic             op_valid,
  output logic             op_in,
  output logic             done,
  output logic             err
`ifdef PARSER_COL_COUNT_EN
  ,
  output logic [15:0]      col_count
`endif
);

  // state   | meaning
  // ACCEPT  | taking bytes, building numbers
  // OP_ST   | number was flushed by operator, emit op_valid next
  // DONE_ST | emit done, then resume
  typedef enum logic [1:0] {ACCEPT, OP_ST, DONE_ST} state_t;

  localparam logic [NUM_W+3:0] SAT = {4'b0000, {NUM_W{1'b1}}};

  state_t           state, state_nxt;
  logic [NUM_W-1:0] acc, acc_nxt, num_in_nxt;
  logic             pending, pending_nxt;
  logic             op_lat, op_lat_nxt;
  logic             num_valid_nxt, op_valid_nxt, op_in_nxt, done_nxt, err_nxt;
  logic             accept, is_digit, is_sep, is_op, is_mul;
  logic [NUM_W+3:0] mac;

  assign in_ready = (state == ACCEPT);
  assign accept   = in_valid && in_ready;
  assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign is_sep   = (in_data == 8'h20) || (in_data == 8'h0A) || (in_data == 8'h0D);
  assign is_mul   = (in_data == 8'h2A);
  assign is_op    = (in_data == 8'h2B) || is_mul;
  // Extra 4 bits make overflow of acc*10+d visible for saturation.
  assign mac      = ({4'b0000, acc} * (NUM_W+4)'(10)) + (NUM_W+4)'(in_data[3:0]);

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    pending_nxt   = pending;
    op_lat_nxt    = op_lat;
    num_valid_nxt = 1'b0;
    num_in_nxt    = num_in;
    op_valid_nxt  = 1'b0;
    op_in_nxt     = op_in;
    done_nxt      = 1'b0;
    err_nxt       = err;
    case (state)
      ACCEPT: begin
        if (accept) begin
          if (is_digit) begin
            pending_nxt = 1'b1;
            if (mac > SAT) begin
              acc_nxt = '1;
              err_nxt = 1'b1;
            end else begin
              acc_nxt = mac[NUM_W-1:0];
            end
          end else if (is_sep || is_op) begin
            if (pending) begin
              num_valid_nxt = 1'b1;
              num_in_nxt    = acc;
              acc_nxt       = '0;
              pending_nxt   = 1'b0;
            end
            if (is_op) begin
              op_lat_nxt = is_mul;
              if (pending) begin
                state_nxt = OP_ST;
              end else begin
                op_valid_nxt = 1'b1;
                op_in_nxt    = is_mul;
                state_nxt    = DONE_ST;
              end
            end
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      OP_ST: begin
        op_valid_nxt = 1'b1;
        op_in_nxt    = op_lat;
        state_nxt    = DONE_ST;
      end
      DONE_ST: begin
        done_nxt  = 1'b1;
        state_nxt = ACCEPT;
      end
      default: state_nxt = ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCEPT;
      acc       <= '0;
      pending   <= 1'b0;
      op_lat    <= 1'b0;
      num_valid <= 1'b0;
      num_in    <= '0;
      op_valid  <= 1'b0;
      op_in     <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      pending   <= pending_nxt;
      op_lat    <= op_lat_nxt;
      num_valid <= num_valid_nxt;
      num_in    <= num_in_nxt;
      op_valid  <= op_valid_nxt;
      op_in     <= op_in_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

`ifdef PARSER_COL_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      col_count <= '0;
    end else if (done) begin
      col_count <= col_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_column_token_parser.sv
// Randomised bench for column_token_parser: event-queue reference model checked every cycle, plus literal checks of the worksheet examples.
module tb_column_token_parser;

  localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, num_valid, op_valid, op_in, done, err;
  logic [31:0] num_in;
`ifdef PARSER_COL_COUNT_EN
  logic [15:0] col_count;
`endif

  column_token_parser #(.NUM_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .num_valid(num_valid), .num_in(num_in),
    .op_valid(op_valid), .op_in(op_in), .done(done), .err(err)
`ifdef PARSER_COL_COUNT_EN
    , .col_count(col_count)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic cmp(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: each accepted byte schedules future strobes in a queue,
  // one strobe per cycle; the source is accepted only while the queue is empty.
  typedef struct {int kind; longint val;} ev_t;  // kind 0=num 1=op 2=done
  ev_t      sched[$];
  ev_t      ev;
  longint   m_acc;
  bit       m_pend, m_valid = 0, m_accept;
  bit       e_nv, e_ov, e_op, e_done, e_err, e_ready;
  longint   e_num;
  logic [15:0] e_cnt;

  task automatic push_ev(input int kind, input longint val);
    ev_t t;
    t.kind = kind;
    t.val  = val;
    sched.push_back(t);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      sched.delete();
      m_acc = 0; m_pend = 0; m_valid = 1;
      e_nv = 0; e_ov = 0; e_op = 0; e_done = 0; e_err = 0; e_num = 0; e_cnt = 0; e_ready = 1;
    end else if (m_valid) begin
      m_accept = in_valid && (sched.size() == 0);
      if (e_done) e_cnt = e_cnt + 16'd1;
      if (m_accept) begin
        if (in_data >= 8'h30 && in_data <= 8'h39) begin
          m_acc = m_acc * 10 + longint'(in_data - 8'h30);
          if (m_acc > MAXV) begin m_acc = MAXV; e_err = 1; end
          m_pend = 1;
        end else if (in_data == 8'h20 || in_data == 8'h0A || in_data == 8'h0D ||
                     in_data == 8'h2B || in_data == 8'h2A) begin
          if (m_pend) begin push_ev(0, m_acc); m_acc = 0; m_pend = 0; end
          if (in_data == 8'h2B || in_data == 8'h2A) begin
            push_ev(1, (in_data == 8'h2A) ? 1 : 0);
            push_ev(2, 0);
          end
        end else begin
          e_err = 1;
        end
      end
      e_nv = 0; e_ov = 0; e_done = 0;
      if (sched.size() > 0) begin
        ev = sched.pop_front();
        case (ev.kind)
          0: begin e_nv = 1; e_num = ev.val; end
          1: begin e_ov = 1; e_op = ev.val[0]; end
          default: e_done = 1;
        endcase
      end
      e_ready = (sched.size() == 0);
    end
  end

  // Observation log of DUT strobes for the literal worksheet checks.
  longint dut_nums[$];
  int     dut_ops[$];
  int     dut_dones, ready_low;

  task automatic clear_log();
    dut_nums.delete();
    dut_ops.delete();
    dut_dones = 0;
    ready_low = 0;
  endtask

  always @(negedge clk) begin
    if (m_valid && !rst) begin
      cmp("in_ready", in_ready, e_ready);
      cmp("num_valid", num_valid, e_nv);
      cmp("num_in", num_in, e_num);
      cmp("op_valid", op_valid, e_ov);
      cmp("op_in", op_in, e_op);
      cmp("done", done, e_done);
      cmp("err", err, e_err);
      cmp("strobe_exclusive", (int'(num_valid) + int'(op_valid) + int'(done)) <= 1, 1);
`ifdef PARSER_COL_COUNT_EN
      cmp("col_count", col_count, e_cnt);
`endif
      if (num_valid === 1'b1) dut_nums.push_back(longint'(num_in));
      if (op_valid === 1'b1) dut_ops.push_back(int'(op_in));
      if (done === 1'b1) dut_dones++;
      if (in_ready === 1'b0) ready_low++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit taken = 0;
    int guard = 0;
    while (!taken) begin
      @(negedge clk);
      in_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = in_valid ? b : 8'($urandom);
      taken    = in_valid && in_ready;
      guard++;
      if (guard > 200) begin
        $display("FAIL byte_accept_timeout: in_ready stuck at %0b, expected 1", in_ready);
        $fatal(1, "byte source stalled");
      end
    end
  endtask

  task automatic send_str(input string s, input bit rnd);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], rnd);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  longint acc_sum, acc_prod;
  string  tok;
  int     guard;

  initial begin
    // Reset values
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cmp("reset_in_ready", in_ready, 1);
    cmp("reset_num_valid", num_valid, 0);
    cmp("reset_num_in", num_in, 0);
    cmp("reset_op_valid", op_valid, 0);
    cmp("reset_done", done, 0);
    cmp("reset_err", err, 0);
    rst = 1'b0;

    clear_log();
    send_str("12 34+", 0);
    idle(6);
    cmp("add_num_count", dut_nums.size(), 2);
    if (dut_nums.size() == 2) begin
      cmp("add_num0", dut_nums[0], 12);
      cmp("add_num1", dut_nums[1], 34);
      acc_sum = dut_nums[0] + dut_nums[1];
      cmp("add_result", acc_sum, 46);
    end
    cmp("add_op", (dut_ops.size() == 1) ? dut_ops[0] : -1, 0);
    cmp("add_done", dut_dones, 1);

    clear_log();
    send_str("3\n4\n5\n*", 0);
    idle(6);
    cmp("mul_num_count", dut_nums.size(), 3);
    acc_prod = 1;
    foreach (dut_nums[i]) acc_prod = acc_prod * dut_nums[i];
    cmp("mul_result", acc_prod, 60);
    cmp("mul_op", (dut_ops.size() == 1) ? dut_ops[0] : -1, 1);
    cmp("mul_ready_low", ready_low, 1);

    clear_log();
    send_str("7*", 0);
    idle(6);
    cmp("pend_num", (dut_nums.size() == 1) ? dut_nums[0] : -1, 7);
    cmp("pend_ready_low", ready_low, 2);
    cmp("pend_done", dut_dones, 1);

    clear_log();
    send_str("4294967296 ", 0);
    idle(3);
    cmp("sat_num", (dut_nums.size() == 1) ? dut_nums[0] : -1, 64'hFFFF_FFFF);
    cmp("sat_err", err, 1);
    do_reset();
    clear_log();
    send_str("9x9 ", 0);
    idle(3);
    cmp("illegal_num", (dut_nums.size() == 1) ? dut_nums[0] : -1, 99);
    cmp("illegal_err", err, 1);

    do_reset();
    clear_log();
    send_str("+", 1);
    idle(5);
    cmp("bare_op_nums", dut_nums.size(), 0);
    cmp("bare_op_op", (dut_ops.size() == 1) ? dut_ops[0] : -1, 0);
    cmp("bare_op_done", dut_dones, 1);

    // Random worksheet tokens with a gappy source; the model checks every cycle.
    do_reset();
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          tok = "";
          repeat ($urandom_range(1, ($urandom_range(0, 9) == 0) ? 12 : 4))
            tok = {tok, string'(8'(8'h30 + $urandom_range(0, 9)))};
          send_str(tok, 1);
        end
        4, 5: send_byte(8'h20, 1);
        6: send_byte(($urandom_range(0, 1) != 0) ? 8'h0A : 8'h0D, 1);
        7, 8: send_byte(($urandom_range(0, 1) != 0) ? 8'h2B : 8'h2A, 1);
        default: send_byte(($urandom_range(0, 3) == 0) ? 8'h78 : 8'h20, 1);
      endcase
    end
    idle(6);

    // Reset while op_valid is high: no done may follow.
    do_reset();
    clear_log();
    send_str("7+", 0);
    guard = 0;
    while (op_valid !== 1'b1 && guard < 20) begin
      @(negedge clk);
      in_valid = 1'b0;
      guard++;
    end
    cmp("op_valid_seen", op_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp("midreset_in_ready", in_ready, 1);
    cmp("midreset_op_valid", op_valid, 0);
    cmp("midreset_num_in", num_in, 0);
    idle(5);
    cmp("midreset_no_done", dut_dones, 0);
    clear_log();
    send_str("5 +", 0);
    idle(6);
    cmp("after_reset_num", (dut_nums.size() == 1) ? dut_nums[0] : -1, 5);
    cmp("after_reset_done", dut_dones, 1);
`ifdef PARSER_COL_COUNT_EN
    cmp("after_reset_col_count", col_count, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
